serial_addsub_mc: RTL
=====================

# serial_addsub_mc

Digit-serial, multi-channel adder/subtractor for LSB-first operand streams. Each valid beat supplies one DIGIT_W-bit digit of operands `a` and `b` for one of CHANNELS time-interleaved operations. Every channel keeps its own carry and mode state between beats. The block sits between serial operand sources and downstream serial consumers, and returns a registered sum digit per beat plus carry-out and signed-overflow flags on the last beat of each operation.

## Interface
- `DIGIT_W`, default 1: bits per beat (≥1).
- `CHANNELS`, default 1: number of independent interleaved operations (≥1).
- `CH_W`, derived: `CHANNELS > 1 ? $clog2(CHANNELS) : 1`.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `vld`  in  1  input beat valid.
- `ch`  in  CH_W  channel of this beat.
- `a`  in  DIGIT_W  operand A digit, LSB-first stream.
- `b`  in  DIGIT_W  operand B digit, LSB-first stream.
- `sub`  in  1  operation mode: 0 = A+B, 1 = A−B. Sampled only on the first beat of an operation.
- `last`  in  1  final (most significant) digit of the operation.
- `out_vld`  out  1  output beat valid.
- `out_ch`  out  CH_W  channel of the output beat.
- `sum`  out  DIGIT_W  result digit.
- `out_last`  out  1  final digit of the result.
- `carry_out`  out  1  carry out of the MSB. For subtraction, 1 = no borrow. Non-zero only when `out_vld && out_last`.
- `overflow`  out  1  two's-complement overflow of the full-width result. Non-zero only when `out_vld && out_last`.

## Operation
- Per-channel state: `busy`, `carry`, `mode`. Reset value of all three is 0.
- Accepted beat: `vld=1` and `ch < CHANNELS`. If `ch >= CHANNELS`, the beat is dropped: no state change and `out_vld=0` next cycle.
- First beat of an operation: channel `busy=0`.
  - Effective mode = `sub`.
  - Effective carry-in = `sub`, which gives two's-complement subtraction.
- Subsequent beats: effective mode = stored `mode`; carry-in = stored `carry`. The `sub` input is ignored.
- Arithmetic: `b_eff = mode ? ~b : b`; `{c, s} = a + b_eff + cin`, computed at DIGIT_W+1 bits.
  - `c_msb` is the carry into bit DIGIT_W−1.
  - `ovf = c ^ c_msb`.
- State update on a non-last beat: `busy=1`, `carry=c`, `mode` = effective mode.
- State update on a last beat: `busy=0`, `carry=0`, `mode=0`. The channel is idle and the next beat on it is a first beat.
- Single-beat operations (first and last on the same beat) are legal.
- `vld=0` cycles, or beats on other channels, between beats of one operation leave that channel's state untouched.
- Operation length is unbounded. The block does not count digits; `last` alone terminates an operation.

## Timing
- All outputs are registered. Latency is 1 cycle: a beat accepted at edge k appears on the outputs after edge k.
- No back-pressure. One beat per cycle, any channel order, including consecutive beats on the same channel.
  - A same-channel beat at k+1 uses the state written at edge k.
- Output register contents:
  - `out_vld` = accepted.
  - `out_ch` = `ch`.
  - `sum` = `s`.
  - `out_last` = `last`.
  - `carry_out` = `last ? c : 0`.
  - `overflow` = `last ? ovf : 0`.
- When no beat is accepted: `out_vld`, `out_last`, `carry_out` and `overflow` go to 0; `sum` and `out_ch` hold their previous values.
- Reset (`rst=0`), asynchronous, including mid-operation:
  - All outputs go to 0.
  - All channels return to idle.
  - After release, the first beat on any channel is a first beat.
  - Beats presented while `rst=0` are ignored.

## Test plan
- **Reset mid-operation:** DIGIT_W=1, CHANNELS=1. Stream 2 beats of an add, assert `rst=0` for one cycle, then send `a=1, b=1, last=1` → all outputs 0 during reset; after reset `sum=0`, `carry_out=1`, `overflow=1` (carry-in 0, not the stale carry).
- **Bit-serial add:** DIGIT_W=1. A=1011, B=0110, `sub=0`, 4 beats → `sum` bits 1,0,0,0; last beat `carry_out=1`, `overflow=0` (−5+6=1).
- **Digit subtract:** DIGIT_W=4, 8-bit operands.
  - 0x30−0x50 → digits 0x0, 0xE; `carry_out=0`, `overflow=0`.
  - 0x70+0x20 → digits 0x0, 0x9; `carry_out=0`, `overflow=1`.
- **Interleaved channels:** CHANNELS=4, DIGIT_W=4. Alternate beats between ch0 (add 0x70+0x20) and ch2 (subtract 0x30−0x50), with ch2 starting one cycle later → each output matches its channel's standalone result; `out_ch` echoes `ch`; `sub` toggled on non-first beats has no effect.
- **Gaps and single-beat:** insert 3 `vld=0` cycles inside an operation → carry preserved and result unchanged; `out_vld=0` during the gaps. A single-beat op with DIGIT_W=4, 0xF+0x1 → `sum=0x0`, `carry_out=1`, `overflow=0`.
- **Illegal channel:** CHANNELS=3, beat with `ch=3` → `out_vld=0` next cycle; an in-flight ch0 operation completes with the correct result.

Source files
------------

// File: rtl/serial_addsub_mc.sv
// rtl/serial_addsub_mc.sv - digit-serial multi-channel adder/subtractor for LSB-first operand streams
module serial_addsub_mc #(
  parameter int DIGIT_W  = 1,
  parameter int CHANNELS = 1,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vld,
  input  logic [CH_W-1:0]    ch,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               sub,
  input  logic               last,
  output logic               out_vld,
  output logic [CH_W-1:0]    out_ch,
  output logic [DIGIT_W-1:0] sum,
  output logic               out_last,
  output logic               carry_out,
  output logic               overflow
);

  // Per-channel operation state: in-progress flag, carry between digits, latched mode
  logic [CHANNELS-1:0] r_busy;
  logic [CHANNELS-1:0] r_carry;
  logic [CHANNELS-1:0] r_mode;

  logic               w_accept;
  logic               w_busy;
  logic               w_carry_st;
  logic               w_mode_st;
  logic               w_mode;
  logic               w_cin;
  logic [DIGIT_W-1:0] w_b_eff;
  logic [DIGIT_W:0]   w_total;
  logic [DIGIT_W-1:0] w_s;
  logic               w_c;
  logic               w_c_msb;
  logic               w_ovf;

  // Beats addressed to a channel that does not exist are dropped entirely
  assign w_accept = vld && (int'(ch) < CHANNELS);

  // Fetch the addressed channel's state; only meaningful for an accepted beat
  always_comb begin
    w_busy     = 1'b0;
    w_carry_st = 1'b0;
    w_mode_st  = 1'b0;
    if (w_accept) begin
      w_busy     = r_busy[ch];
      w_carry_st = r_carry[ch];
      w_mode_st  = r_mode[ch];
    end
  end

  // First beat takes mode from sub and seeds carry-in with it (A + ~B + 1)
  assign w_mode  = w_busy ? w_mode_st  : sub;
  assign w_cin   = w_busy ? w_carry_st : sub;
  assign w_b_eff = w_mode ? ~b : b;
  assign w_total = {1'b0, a} + {1'b0, w_b_eff} + {{DIGIT_W{1'b0}}, w_cin};
  assign w_s     = w_total[DIGIT_W-1:0];
  assign w_c     = w_total[DIGIT_W];
  // Carry into the top bit recovered from the top-bit sum: s = a ^ b ^ cin
  assign w_c_msb = a[DIGIT_W-1] ^ w_b_eff[DIGIT_W-1] ^ w_s[DIGIT_W-1];
  assign w_ovf   = w_c ^ w_c_msb;

  // Update the addressed channel; a last beat returns it to idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy  <= '0;
      r_carry <= '0;
      r_mode  <= '0;
    end else if (w_accept) begin
      r_busy[ch]  <= !last;
      r_carry[ch] <= last ? 1'b0 : w_c;
      r_mode[ch]  <= last ? 1'b0 : w_mode;
    end
  end

  // Output register; flags only on the final digit, sum/channel hold when idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_vld   <= 1'b0;
      out_ch    <= '0;
      sum       <= '0;
      out_last  <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_vld   <= w_accept;
      out_last  <= w_accept && last;
      carry_out <= w_accept && last && w_c;
      overflow  <= w_accept && last && w_ovf;
      if (w_accept) begin
        out_ch <= ch;
        sum    <= w_s;
      end
    end
  end

endmodule
